fetch_decode_stage: RTL and testbench

- Fetch stage plus IF/ID pipeline register for the pipelined RV32I core.
- Owns the fetch PC and drives a single-outstanding-request instruction-memory handshake.
- Buffers the returned word under decode stall and applies branch/jump redirects and flushes.
- Its decode-side outputs feed the decode stage directly; imm_field_d (instr[31:7]) drives the immediate extender's 25-bit instruction input.

---
 rtl/fetch_decode_stage.sv | 131 +++++++++++++
 tb/tb_fetch_decode_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_stage.sv
// Fetch stage and IF/ID pipeline register: owns the fetch PC, runs a
// single-outstanding instruction-memory handshake, parks words under stall and applies redirects.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_d,
  output logic [24:0] imm_field_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

  typedef enum logic [1:0] {REQ, HOLD, DISCARD} state_t;

  state_t      state, state_next;
  logic        running;
  logic [31:0] pc_f, pc_f_next;
  logic [31:0] disc_addr, disc_addr_next;
  logic [31:0] hold_instr, hold_pc;
  logic        hold_load;
  logic [31:0] instr_next, pc_d_next;
  logic        valid_next;
  logic        fire;
  logic [31:0] target;

  // running keeps the request low until the first edge after reset release
  assign imem_req    = running && (state != HOLD);
  assign imem_addr   = (state == DISCARD) ? disc_addr : pc_f;
  assign fire        = imem_req && imem_ack;
  assign target      = {redirect_pc[31:2], 2'b00};
  assign imm_field_d = instr_d[31:7];
  assign pc_plus4_d  = pc_d + 32'd4;

  always_comb begin
    state_next     = state;
    pc_f_next      = pc_f;
    disc_addr_next = disc_addr;
    hold_load      = 1'b0;
    instr_next     = instr_d;
    pc_d_next      = pc_d;
    valid_next     = valid_d;

    case (state)
      REQ: begin
        if (redirect) begin
          pc_f_next = target;
          if (!fire) begin
            state_next     = DISCARD;
            disc_addr_next = pc_f;
          end
        end else if (fire) begin
          pc_f_next = pc_f + 32'd4;
          if (stall_d) begin
            hold_load  = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_f_next  = target;
          state_next = REQ;
        end else if (flush_d || !stall_d) begin
          state_next = REQ;
        end
      end
      DISCARD: begin
        if (redirect) pc_f_next = target;
        if (fire) state_next = REQ;
      end
      default: state_next = REQ;
    endcase

    // IF/ID priority: flush, then stall, then a real load; otherwise a bubble
    if (flush_d) begin
      instr_next = NOP_INSTR;
      valid_next = 1'b0;
    end else if (stall_d) begin
      instr_next = instr_d;
    end else if (state == REQ && fire && !redirect) begin
      instr_next = imem_rdata;
      pc_d_next  = pc_f;
      valid_next = 1'b1;
    end else if (state == HOLD && !redirect) begin
      instr_next = hold_instr;
      pc_d_next  = hold_pc;
      valid_next = 1'b1;
    end else begin
      instr_next = NOP_INSTR;
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= REQ;
      running    <= 1'b0;
      pc_f       <= RESET_PC;
      disc_addr  <= RESET_PC;
      hold_instr <= NOP_INSTR;
      hold_pc    <= 32'h0;
      instr_d    <= NOP_INSTR;
      pc_d       <= 32'h0;
      valid_d    <= 1'b0;
    end else begin
      state     <= state_next;
      running   <= 1'b1;
      pc_f      <= pc_f_next;
      disc_addr <= disc_addr_next;
      if (hold_load) begin
        hold_instr <= imem_rdata;
        hold_pc    <= pc_f;
      end
      instr_d <= instr_next;
      pc_d    <= pc_d_next;
      valid_d <= valid_next;
    end
  end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: a second instance starts at 32'hFFFFFFFC to cover PC wrap.
module tb_fetch_decode_stage;

  logic        clk;
  logic        rst;
  logic        imem_ack;
  logic        stall_d, flush_d, redirect;
  logic [31:0] redirect_pc;

  logic        imem_req, imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic [31:0] imem_rdata, imem_rdata2;
  logic [31:0] instr_d, instr_d2;
  logic [24:0] imm_field_d, imm_field_d2;
  logic [31:0] pc_d, pc_d2, pc_plus4_d, pc_plus4_d2;
  logic        valid_d, valid_d2;

  int tests_run = 0;
  int tests_failed = 0;

  // Memory image: addr 0 holds addi x1,x0,5; other words are unique per address
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h00500093 + (a << 12);
  endfunction

  assign imem_rdata  = word(imem_addr);
  assign imem_rdata2 = word(imem_addr2);

  fetch_decode_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall_d(stall_d), .flush_d(flush_d), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_d(instr_d), .imm_field_d(imm_field_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d)
  );

  fetch_decode_stage #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack), .imem_rdata(imem_rdata2),
    .stall_d(stall_d), .flush_d(flush_d), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_d(instr_d2), .imm_field_d(imm_field_d2), .pc_d(pc_d2), .pc_plus4_d(pc_plus4_d2),
    .valid_d(valid_d2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; imem_ack = 1'b1; stall_d = 1'b0; flush_d = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0;

    step(); step();
    check("rst_instr", instr_d, 32'h00000013);
    check("rst_pc", pc_d, 32'h0);
    check("rst_valid", {31'b0, valid_d}, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    rst = 1'b1;

    step();
    check("first_req", {31'b0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h0);
    check("wrap_addr0", imem_addr2, 32'hFFFFFFFC);

    step();
    check("cap0_instr", instr_d, 32'h00500093);
    check("cap0_pc", pc_d, 32'h0);
    check("cap0_valid", {31'b0, valid_d}, 32'h1);
    check("cap0_imm", {7'b0, imm_field_d}, 32'h0000A001);
    check("cap0_pc4", pc_plus4_d, 32'h4);
    check("wrap_pc", pc_d2, 32'hFFFFFFFC);
    check("wrap_pc4", pc_plus4_d2, 32'h0);
    check("wrap_next_addr", imem_addr2, 32'h0);

    step();
    check("cap4_pc", pc_d, 32'h4);
    check("cap4_instr", instr_d, 32'h00504093);
    check("cap4_nextaddr", imem_addr, 32'h8);
    imem_ack = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_req", {31'b0, imem_req}, 32'h1);
      check("wait_addr", imem_addr, 32'h8);
      check("wait_valid", {31'b0, valid_d}, 32'h0);
      check("wait_instr", instr_d, 32'h00000013);
      check("wait_pc", pc_d, 32'h4);
    end
    imem_ack = 1'b1;

    step();
    check("cap8_pc", pc_d, 32'h8);
    check("cap8_valid", {31'b0, valid_d}, 32'h1);
    check("cap8_instr", instr_d, 32'h00508093);
    stall_d = 1'b1;

    step();
    check("stall1_pc", pc_d, 32'h8);
    check("stall1_instr", instr_d, 32'h00508093);
    check("stall1_req", {31'b0, imem_req}, 32'h0);

    step();
    check("stall2_pc", pc_d, 32'h8);
    check("stall2_req", {31'b0, imem_req}, 32'h0);
    stall_d = 1'b0;

    step();
    check("hold_pc", pc_d, 32'hC);
    check("hold_instr", instr_d, 32'h0050C093);
    check("hold_valid", {31'b0, valid_d}, 32'h1);
    check("resume_req", {31'b0, imem_req}, 32'h1);
    check("resume_addr", imem_addr, 32'h10);

    step();
    check("cap16_pc", pc_d, 32'h10);
    check("cap16_nextaddr", imem_addr, 32'h14);
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h00000103; flush_d = 1'b1;

    step();
    redirect = 1'b0; flush_d = 1'b0;
    check("disc_req", {31'b0, imem_req}, 32'h1);
    check("disc_addr", imem_addr, 32'h14);
    check("disc_valid", {31'b0, valid_d}, 32'h0);

    step();
    check("disc2_addr", imem_addr, 32'h14);
    check("disc2_valid", {31'b0, valid_d}, 32'h0);
    imem_ack = 1'b1;

    step();
    check("drop_valid", {31'b0, valid_d}, 32'h0);
    check("new_addr", imem_addr, 32'h100);
    check("new_req", {31'b0, imem_req}, 32'h1);

    step();
    check("new_pc", pc_d, 32'h100);
    check("new_valid", {31'b0, valid_d}, 32'h1);
    check("new_instr", instr_d, 32'h00600093);
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;

    step();
    redirect = 1'b0;
    check("disc3_addr", imem_addr, 32'h104);
    #2 rst = 1'b0;
    #1;
    check("arst_req", {31'b0, imem_req}, 32'h0);
    check("arst_valid", {31'b0, valid_d}, 32'h0);
    check("arst_instr", instr_d, 32'h00000013);
    check("arst_pc", pc_d, 32'h0);
    check("arst_addr", imem_addr, 32'h0);

    step();
    rst = 1'b1; imem_ack = 1'b1;
    step();
    check("restart_req", {31'b0, imem_req}, 32'h1);
    check("restart_addr", imem_addr, 32'h0);
    step();
    check("restart_pc", pc_d, 32'h0);
    check("restart_valid", {31'b0, valid_d}, 32'h1);
    check("restart_instr", instr_d, 32'h00500093);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
